// File: rtl/memory_cycle_pkg.sv
// rtl/memory_cycle_pkg.sv - shared types, funct3 codes and lane helpers for the memory stage
package mem_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ALU      = 2'd0,
        DATA_MEM = 2'd1,
        PC       = 2'd2
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - data memory request/response bus
interface memory_cycle_if #(parameter int XLEN = 32);
    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic [3:0]      dm_be;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/memory_cycle_load_align.sv
// rtl/memory_cycle_load_align.sv - load lane extraction and sign/zero extension
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[{lane, 3'b000} +: 8];
        lane_half = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            F3_LH:   data = {{(XLEN-16){lane_half[15]}}, lane_half};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, lane_byte};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, lane_half};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - memory pipeline stage: issues loads/stores and registers writeback
module memory_cycle
    import mem_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [XLEN-1:0]  ex_alu_data,
    input  logic [XLEN-1:0]  ex_store_data,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic [2:0]       ex_funct3,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic [1:0]       ex_writeback_data_sel,
    memory_cycle_if.master   dm,
    output logic             wb_valid,
    output logic [XLEN-1:0]  alu_data_out,
    output logic [XLEN-1:0]  PC_out,
    output logic [XLEN-1:0]  dm_read_data,
    output logic [1:0]       writeback_data_sel,
    output logic [4:0]       wb_rd,
    output logic             wb_reg_write,
    output logic             misalign
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_WAIT = ST_WAIT;

    logic [1:0]      state, next_state;
    logic [XLEN-1:0] alu_q, pc_q, load_data, store_lanes;
    logic [4:0]      rd_q;
    logic [1:0]      sel_q;
    logic [2:0]      f3_q;
    logic            rw_q, load_q;
    logic            is_mem, mis, start_access;
    logic            retire, ret_from_ex, ret_rw, ret_mis, ret_load;

    assign ex_ready     = (state == S_IDLE);
    assign is_mem       = ex_mem_read | ex_mem_write;
    assign mis          = misaligned(ex_funct3, ex_alu_data[1:0]);
    assign start_access = ex_ready && ex_valid && is_mem && !mis;

    always_comb begin
        case (ex_funct3[1:0])
            2'b00:   store_lanes = {(XLEN/8){ex_store_data[7:0]}};
            2'b01:   store_lanes = {(XLEN/16){ex_store_data[15:0]}};
            default: store_lanes = ex_store_data;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dm.dm_rdata),
        .lane   (alu_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    // Every path that completes an instruction funnels through retire.
    always_comb begin
        next_state  = state;
        retire      = 1'b0;
        ret_from_ex = 1'b0;
        ret_rw      = rw_q;
        ret_mis     = 1'b0;
        ret_load    = 1'b0;
        case (state)
            S_IDLE: if (ex_valid) begin
                if (!is_mem || mis) begin
                    retire      = 1'b1;
                    ret_from_ex = 1'b1;
                    ret_rw      = ex_reg_write && !is_mem;
                    ret_mis     = is_mem;
                end else begin
                    next_state = S_REQ;
                end
            end
            S_REQ: if (dm.dm_gnt) begin
                if (!load_q) begin
                    retire     = 1'b1;
                    ret_rw     = 1'b0;
                    next_state = S_IDLE;
                end else if (dm.dm_rvalid) begin
                    retire     = 1'b1;
                    ret_load   = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: if (dm.dm_rvalid) begin
                retire     = 1'b1;
                ret_load   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            alu_q              <= '0;
            pc_q               <= '0;
            rd_q               <= '0;
            sel_q              <= '0;
            f3_q               <= '0;
            rw_q               <= 1'b0;
            load_q             <= 1'b0;
            dm.dm_req          <= 1'b0;
            dm.dm_we           <= 1'b0;
            dm.dm_addr         <= '0;
            dm.dm_wdata        <= '0;
            dm.dm_be           <= '0;
            wb_valid           <= 1'b0;
            alu_data_out       <= '0;
            PC_out             <= '0;
            dm_read_data       <= '0;
            writeback_data_sel <= '0;
            wb_rd              <= '0;
            wb_reg_write       <= 1'b0;
            misalign           <= 1'b0;
        end else begin
            state    <= next_state;
            wb_valid <= retire;
            if (start_access) begin
                alu_q       <= ex_alu_data;
                pc_q        <= ex_pc;
                rd_q        <= ex_rd;
                sel_q       <= ex_writeback_data_sel;
                f3_q        <= ex_funct3;
                rw_q        <= ex_reg_write;
                load_q      <= ex_mem_read;
                dm.dm_req   <= 1'b1;
                dm.dm_we    <= !ex_mem_read;
                dm.dm_addr  <= {ex_alu_data[XLEN-1:2], 2'b00};
                dm.dm_wdata <= store_lanes;
                dm.dm_be    <= byte_enable(ex_funct3, ex_alu_data[1:0]);
            end else if (state == S_REQ && dm.dm_gnt) begin
                dm.dm_req <= 1'b0;
            end
            if (retire) begin
                alu_data_out       <= ret_from_ex ? ex_alu_data : alu_q;
                PC_out             <= ret_from_ex ? ex_pc : pc_q;
                writeback_data_sel <= ret_from_ex ? ex_writeback_data_sel : sel_q;
                wb_rd              <= ret_from_ex ? ex_rd : rd_q;
                wb_reg_write       <= ret_rw;
                misalign           <= ret_mis;
                if (ret_load)
                    dm_read_data <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - scoreboard bench for memory_cycle with directed vectors
module tb_memory_cycle;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_data = '0, ex_store_data = '0, ex_pc = '0;
    logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic [1:0]  ex_writeback_data_sel = '0;
    logic        wb_valid, wb_reg_write, misalign;
    logic [31:0] alu_data_out, PC_out, dm_read_data;
    logic [1:0]  writeback_data_sel;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;
    wb_t exp_q[$];
    logic [31:0] last_rdata = '0;

    memory_cycle_if #(.XLEN(32)) dm ();

    memory_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_data(ex_alu_data), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_writeback_data_sel(ex_writeback_data_sel),
        .dm(dm),
        .wb_valid(wb_valid), .alu_data_out(alu_data_out), .PC_out(PC_out),
        .dm_read_data(dm_read_data), .writeback_data_sel(writeback_data_sel),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .misalign(misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            wb_t act, e;
            act = '{alu_data_out, PC_out, dm_read_data, writeback_data_sel, wb_rd, wb_reg_write, misalign};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got %h, expected no wb_valid", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL wb_record: got alu=%h pc=%h rdata=%h sel=%0d rd=%0d rw=%b mis=%b, expected alu=%h pc=%h rdata=%h sel=%0d rd=%0d rw=%b mis=%b",
                             act.alu, act.pc, act.rdata, act.sel, act.rd, act.rw, act.mis,
                             e.alu, e.pc, e.rdata, e.sel, e.rd, e.rw, e.mis);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] rdata,
                             input logic [1:0] sel, input logic [4:0] rd, input logic rw, input logic mis);
        exp_q.push_back('{alu, pc, rdata, sel, rd, rw, mis});
        last_rdata = rdata;
    endtask

    task automatic issue(input logic [2:0] f3, input logic mr, input logic mw, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] rd,
                         input logic rw, input logic [1:0] sel);
        @(negedge clk);
        chk("ex_ready_before_issue", {31'd0, ex_ready}, 32'd1);
        ex_funct3 = f3; ex_mem_read = mr; ex_mem_write = mw; ex_alu_data = alu;
        ex_store_data = sd; ex_pc = pc; ex_rd = rd; ex_reg_write = rw;
        ex_writeback_data_sel = sel; ex_valid = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    task automatic mem_grant(input logic rv, input logic [31:0] rdata);
        @(negedge clk);
        dm.dm_gnt = 1'b1; dm.dm_rvalid = rv; dm.dm_rdata = rdata;
        @(posedge clk); #1;
        dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0;
    endtask

    task automatic mem_return(input logic [31:0] rdata);
        @(negedge clk);
        dm.dm_rvalid = 1'b1; dm.dm_rdata = rdata;
        @(posedge clk); #1;
        dm.dm_rvalid = 1'b0;
    endtask

    initial begin
        dm.dm_gnt = 1'b0; dm.dm_rvalid = 1'b0; dm.dm_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset_dm_req", {31'd0, dm.dm_req}, 32'd0);
        chk("reset_dm_be", {28'd0, dm.dm_be}, 32'd0);
        chk("reset_alu_data_out", alu_data_out, 32'd0);

        // ALU op: one-cycle writeback, no memory request
        expect_wb(32'h0000_00AA, 32'h1000, last_rdata, ALU, 5'd5, 1'b1, 1'b0);
        issue(3'b000, 1'b0, 1'b0, 32'h0000_00AA, 32'h0, 32'h1000, 5'd5, 1'b1, ALU);
        @(negedge clk);
        chk("alu_no_dm_req", {31'd0, dm.dm_req}, 32'd0);

        // SB 0x12 @ 0x103, grant held off for three cycles
        expect_wb(32'h0000_0103, 32'h1004, last_rdata, ALU, 5'd0, 1'b0, 1'b0);
        issue(F3_SB, 1'b0, 1'b1, 32'h0000_0103, 32'h0000_0012, 32'h1004, 5'd0, 1'b1, ALU);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sb_dm_req_held", {31'd0, dm.dm_req}, 32'd1);
            chk("sb_dm_be", {28'd0, dm.dm_be}, 32'h8);
            chk("sb_dm_wdata", dm.dm_wdata, 32'h1212_1212);
            chk("sb_dm_addr", dm.dm_addr, 32'h0000_0100);
        end
        chk("sb_dm_we", {31'd0, dm.dm_we}, 32'd1);
        dm.dm_gnt = 1'b1;
        @(posedge clk); #1 dm.dm_gnt = 1'b0;
        @(negedge clk);
        chk("sb_dm_req_dropped", {31'd0, dm.dm_req}, 32'd0);

        // SH 0xBEEF @ 0x102
        expect_wb(32'h0000_0102, 32'h1008, last_rdata, ALU, 5'd0, 1'b0, 1'b0);
        issue(F3_SH, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_BEEF, 32'h1008, 5'd0, 1'b0, ALU);
        @(negedge clk);
        chk("sh_dm_be", {28'd0, dm.dm_be}, 32'hC);
        chk("sh_dm_wdata", dm.dm_wdata, 32'hBEEF_BEEF);
        mem_grant(1'b0, 32'h0);

        // LB / LBU @ 0x2 via WAIT
        expect_wb(32'h0000_0002, 32'h100C, 32'hFFFF_FF80, DATA_MEM, 5'd7, 1'b1, 1'b0);
        issue(F3_LB, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 32'h100C, 5'd7, 1'b1, DATA_MEM);
        mem_grant(1'b0, 32'h0);
        mem_return(32'h0080_0000);
        expect_wb(32'h0000_0002, 32'h1010, 32'h0000_0080, DATA_MEM, 5'd8, 1'b1, 1'b0);
        issue(F3_LBU, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 32'h1010, 5'd8, 1'b1, DATA_MEM);
        mem_grant(1'b0, 32'h0);
        mem_return(32'h0080_0000);

        // LH / LHU @ 0x2, grant and data together
        expect_wb(32'h0000_0002, 32'h1014, 32'hFFFF_8001, DATA_MEM, 5'd9, 1'b1, 1'b0);
        issue(F3_LH, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 32'h1014, 5'd9, 1'b1, DATA_MEM);
        mem_grant(1'b1, 32'h8001_0000);
        expect_wb(32'h0000_0002, 32'h1018, 32'h0000_8001, DATA_MEM, 5'd10, 1'b1, 1'b0);
        issue(F3_LHU, 1'b1, 1'b0, 32'h0000_0002, 32'h0, 32'h1018, 5'd10, 1'b1, DATA_MEM);
        mem_grant(1'b1, 32'h8001_0000);

        // Misaligned LW @ 0x6 and LH @ 0x3
        expect_wb(32'h0000_0006, 32'h101C, last_rdata, DATA_MEM, 5'd11, 1'b0, 1'b1);
        issue(F3_LW, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 32'h101C, 5'd11, 1'b1, DATA_MEM);
        @(negedge clk);
        chk("lw_mis_no_dm_req", {31'd0, dm.dm_req}, 32'd0);
        expect_wb(32'h0000_0003, 32'h1020, last_rdata, DATA_MEM, 5'd12, 1'b0, 1'b1);
        issue(F3_LH, 1'b1, 1'b0, 32'h0000_0003, 32'h0, 32'h1020, 5'd12, 1'b1, DATA_MEM);
        @(negedge clk);
        chk("lh_mis_no_dm_req", {31'd0, dm.dm_req}, 32'd0);

        // Read and write both set: treated as a load
        expect_wb(32'h0000_0008, 32'h1024, 32'hCAFE_F00D, DATA_MEM, 5'd13, 1'b1, 1'b0);
        issue(F3_LW, 1'b1, 1'b1, 32'h0000_0008, 32'h5555_5555, 32'h1024, 5'd13, 1'b1, DATA_MEM);
        @(negedge clk);
        chk("rw_both_dm_we", {31'd0, dm.dm_we}, 32'd0);
        mem_grant(1'b1, 32'hCAFE_F00D);

        // LW with same-cycle grant and data, then back-to-back ALU op
        expect_wb(32'h0000_0020, 32'h1028, 32'h1234_5678, DATA_MEM, 5'd14, 1'b1, 1'b0);
        issue(F3_LW, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h1028, 5'd14, 1'b1, DATA_MEM);
        mem_grant(1'b1, 32'h1234_5678);
        expect_wb(32'h0000_0055, 32'h102C, last_rdata, PC, 5'd15, 1'b1, 1'b0);
        issue(3'b000, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 32'h102C, 5'd15, 1'b1, PC);

        // Reset while waiting for load data; late rvalid must be ignored
        issue(F3_LW, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1030, 5'd16, 1'b1, DATA_MEM);
        mem_grant(1'b0, 32'h0);
        @(negedge clk) rst = 1'b1;
        last_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        dm.dm_rvalid = 1'b1; dm.dm_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1 dm.dm_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("post_rst_dm_read_data", dm_read_data, 32'd0);
        chk("post_rst_dm_req", {31'd0, dm.dm_req}, 32'd0);

        expect_wb(32'h0000_0077, 32'h2000, last_rdata, ALU, 5'd1, 1'b1, 1'b0);
        issue(3'b000, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 32'h2000, 5'd1, 1'b1, ALU);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  execute stage presents an instruction.
REQ-005 ex_ready  out  1  stage accepts the instruction this cycle.
REQ-006 ex_alu_data  in  XLEN  ALU result; the byte address for loads and stores.
REQ-007 ex_store_data  in  XLEN  rs2 value for stores.
REQ-008 ex_pc  in  XLEN  instruction PC.
REQ-009 ex_mem_read / ex_mem_write  in  1 each  load / store instruction.
REQ-010 ex_funct3  in  3  access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-011 ex_rd  in  5; ex_reg_write  in  1; ex_writeback_data_sel  in  2.
REQ-012 dm_req  out  1; dm_we  out  1; dm_addr  out  XLEN, word aligned; dm_wdata  out  XLEN; dm_be  out  4.
REQ-013 dm_gnt  in  1  request accepted; dm_rvalid  in  1 and dm_rdata  in  XLEN  load data return.
REQ-014 wb_valid  out  1; alu_data_out, PC_out, dm_read_data  out  XLEN; writeback_data_sel  out  2; wb_rd  out  5; wb_reg_write  out  1; misalign  out  1.

Function
REQ-015 FSM states: IDLE, REQ, WAIT. ex_ready is 1 only in IDLE.
REQ-016 IDLE with ex_valid and a non-memory instruction: capture into the output register; wb_valid=1 the next cycle (1-cycle latency); state stays IDLE.
REQ-017 IDLE with ex_valid and an aligned load or store: latch the operands, go to REQ, and drive dm_req=1 from the next cycle.
REQ-018 In REQ, dm_req, dm_we, dm_addr, dm_wdata and dm_be are held stable until dm_gnt=1.
REQ-019 Store granted: go to IDLE; wb_valid=1 the next cycle with wb_reg_write=0.
REQ-020 Load granted: go to WAIT. If dm_rvalid arrives in the same cycle as dm_gnt, the data is taken and the FSM goes directly to IDLE.
REQ-021 In WAIT, on dm_rvalid: dm_read_data=extended data, wb_valid=1 the next cycle, state returns to IDLE.
REQ-022 dm_addr = {ex_alu_data[XLEN-1:2], 2'b00}.
REQ-023 dm_be encoding:
 - SB: 4'b0001<<addr[1:0]
 - SH: 4'b0011<<addr[1:0]
 - SW: 4'b1111
REQ-024 dm_wdata replicates the store byte (SB) or halfword (SH) across all lanes.
REQ-025 Loads select the byte/halfword at addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes through unchanged.
REQ-026 Misalignment (halfword with addr[0]=1, word with addr[1:0]!=0): no dm_req is issued; wb_valid=1 the next cycle with misalign=1 and wb_reg_write=0.
REQ-027 wb_valid is a single-cycle pulse per instruction; writeback never stalls.
REQ-028 All wb_* and data outputs hold their last values while wb_valid=0.
REQ-029 An instruction with both ex_mem_read and ex_mem_write set is treated as a load.
REQ-030 alu_data_out, PC_out, writeback_data_sel and wb_rd are registered copies of the latched execute inputs.

Reset
REQ-031 On rst, the FSM goes to IDLE and all of the following are cleared to 0:
 - dm_req, dm_we, dm_be
 - wb_valid, wb_reg_write, misalign
 - all data outputs
REQ-032 A reset in REQ or WAIT abandons the access; a dm_rvalid arriving after reset is ignored.
REQ-033 ex_ready=1 in the first cycle after rst deasserts.

Structure
REQ-034 Package mem_pkg holds:
 - XLEN default
 - writeback select enum: ALU=0, DATA_MEM=1, PC=2
 - funct3 load/store constants
 - FSM state enum
REQ-035 One sub-module, load_align, is purely combinational and implements lane extraction and extension from dm_rdata, addr[1:0] and funct3.

Verification
REQ-036 ALU op, ex_alu_data=0x0000_00AA -> next cycle wb_valid=1, alu_data_out=0xAA, no dm_req.
REQ-037 SB of 0x12 at address 0x103 -> dm_be=4'b1000, dm_wdata=0x1212_1212, dm_addr=0x100; dm_req is held for 3 cycles with dm_gnt low.
REQ-038 LB at address 0x2 with dm_rdata=0x0080_0000 -> dm_read_data=0xFFFF_FF80; the same access with LBU gives 0x0000_0080.
REQ-039 LW at address 0x6 -> misalign=1, wb_reg_write=0, dm_req never asserts.
REQ-040 rst asserted in WAIT, then dm_rvalid=1 -> no wb_valid; ex_ready=1 after rst deasserts.
REQ-041 Load with dm_gnt and dm_rvalid in the same cycle, dm_rdata=0x1234_5678, LW -> dm_read_data=0x1234_5678; the next instruction is accepted the cycle after.
